mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store front-end sitting directly upstream of the CPU data memory.
- The data memory only supports combinational word reads and full-word synchronous writes. This block adds sub-word access on top of that.
- Loads: LB/LH/LW/LBU/LHU with lane extraction and sign/zero extension.
- Stores: SB/SH via a read-modify-write sequence; SW as a direct write.
- Accepts one request at a time over a valid/ready handshake and reports completion with a Done pulse and an Error flag.

Parameters:
- BITS_ADDR, 8, byte-address width of data memory (2**BITS_ADDR bytes); memory word index is BITS_ADDR-2 bits.

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- ReqValid  in  1  request present
- ReqReady  out  1  block can accept a request (high only in IDLE)
- ReqWrite  in  1  1 = store, 0 = load
- Funct3  in  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU legal for loads only)
- Addr  in  32  byte address
- StoreData  in  32  store value, right-aligned
- LoadData  out  32  extended load result, registered
- Done  out  1  one-cycle completion pulse
- Error  out  1  valid with Done; request rejected
- MemAddr  out  BITS_ADDR-2  word index to data memory = registered Addr[BITS_ADDR-1:2]
- MemWData  out  32  word written to data memory
- MemWE  out  1  data-memory write enable
- MemRData  in  32  combinational read word from data memory

Behaviour:
- Byte lanes within a word are little-endian: Addr[1:0]=0 selects bits[7:0], 3 selects bits[31:24]. Halfword Addr[1]=0 selects bits[15:0].
- Reset (async, immediate): state=IDLE, LoadData=0, Done=0, Error=0, merge buffer=0.
- MemWE is decoded combinationally from state, so reset deasserts it immediately. Reset mid-operation aborts the operation with no write and no Done.
- IDLE:
  - ReqReady=1.
  - On ReqValid, register Addr, Funct3, ReqWrite, StoreData.
  - Error case, next state ERR: misaligned (H with Addr[0]=1; W with Addr[1:0]!=0), illegal Funct3 (011, 110, 111), or BU/HU with ReqWrite=1.
  - Otherwise: load or SB/SH go to RD; SW goes to WR.
- RD:
  - MemAddr held.
  - Load: LoadData <= extracted lane, sign-extended for B/H, zero-extended for BU/HU/W; next state DONE.
  - SB/SH: merge buffer <= MemRData with the addressed lane replaced by StoreData[7:0] or [15:0]; next state WR.
- WR: MemWE=1 for exactly one cycle. MemWData = merge buffer (SB/SH) or registered StoreData (SW). Next state DONE.
- DONE: Done=1, Error=0; next state IDLE.
- ERR: Done=1, Error=1, MemWE never asserted, LoadData unchanged; next state IDLE.
- Outside WR, MemWE=0 and MemWData=merge buffer (don't-care).
- Latency from the accept edge T:
  - load: Done at T+2
  - SW: write at T+1, Done at T+2
  - SB/SH: read at T+1, write at T+2, Done at T+3
  - error: Done at T+1
- ReqValid outside IDLE is ignored; the requester must hold it until ReqReady.
- A new request is accepted in the IDLE cycle following Done. Throughput is at most one request per 3 cycles (loads).
- LoadData holds its value until the next successful load; stores do not alter it.
- Addr bits above BITS_ADDR-1 are ignored (aliasing) unless the optional feature is enabled.

Optional Feature:
- Macro MEM_BOUNDS_CHECK_EN.
- Defined: Addr[31:BITS_ADDR]!=0 is an additional error condition in IDLE, leading to ERR (Done+Error at T+1, no memory write).
- Undefined: upper bits are ignored and accesses wrap modulo 2**BITS_ADDR.

Decomposition:
- Package mem_access_pkg: Funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the state encoding (IDLE, RD, WR, DONE, ERR, 3-bit).
- One combinational sub-module, subword_align:
  - inputs: word, Addr[1:0], Funct3, StoreData
  - outputs: extended load value and merged store word
  - used by the FSM in RD.

Test Plan:
- Preload word index 4 = 0x8899AABB; LB Addr=0x13 -> LoadData=0xFFFFFF88, Done at T+2, MemWE never high.
- Same word; LHU Addr=0x12 -> 0x00008899; LBU Addr=0x10 -> 0x000000BB; LW Addr=0x10 -> 0x8899AABB.
- SH Addr=0x12 StoreData=0xDEAD1234 -> one MemWE pulse at T+2 with MemWData=0x1234AABB; Done at T+3; subsequent LW returns 0x1234AABB.
- LW Addr=0x11, and SH Addr=0x13 -> Error=1 with Done at T+1, no MemWE; then SB with Funct3=100 -> Error.
- SB Addr=0x10 StoreData=0x77, RST pulsed during RD -> MemWE never asserted, no Done, ReqReady=1 immediately; memory still 0x8899AABB.
- With MEM_BOUNDS_CHECK_EN: LW Addr=0x100 -> Error. Without: LW Addr=0x110 -> 0x8899AABB.

Source files
------------

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: width codes, FSM encoding and request legality check for mem_access_unit
package mem_access_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [2:0] {IDLE, RD, WR, DONE, ERR} state_t;
  // Illegal code, misaligned halfword/word, or unsigned width on a store.
  function automatic logic f3_bad(input logic [2:0] f3, input logic [1:0] off, input logic wr);
    return f3 == 3'b011 || f3[2:1] == 2'b11 || ((f3 == F3_H || f3 == F3_HU) && off[0]) ||
           (f3 == F3_W && off != 2'b00) || (f3[2] && wr);
  endfunction
endpackage

// File: rtl/subword_align.sv
// subword_align: little-endian lane extraction/extension for loads and lane merge for stores
// Ports: word_i memory word, off_i byte offset, f3_i width code, sdata_i right-aligned store value,
//        load_o extended load value, store_o word with the addressed lane replaced.
module subword_align
  import mem_access_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  f3_i,
  input  logic [31:0] sdata_i,
  output logic [31:0] load_o,
  output logic [31:0] store_o
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = word_i[{off_i, 3'b000} +: 8];
  assign h = off_i[1] ? word_i[31:16] : word_i[15:0];
  assign load_o = f3_i == F3_B  ? {{24{b[7]}}, b} :
                  f3_i == F3_H  ? {{16{h[15]}}, h} :
                  f3_i == F3_BU ? {24'h0, b} :
                  f3_i == F3_HU ? {16'h0, h} : word_i;
  always_comb begin
    store_o = word_i;
    if (f3_i == F3_B) store_o[{off_i, 3'b000} +: 8] = sdata_i[7:0];
    else if (f3_i == F3_H) store_o[{off_i[1], 4'b0000} +: 16] = sdata_i[15:0];
    else store_o = sdata_i;
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front-end adding sub-word access to a word-only data memory
// Ports: CLK/RST (async active-high); ReqValid/ReqReady/ReqWrite/Funct3/Addr/StoreData request;
//        LoadData/Done/Error completion; MemAddr/MemWData/MemWE/MemRData data-memory side.
// Optional MEM_BOUNDS_CHECK_EN: nonzero Addr[31:BITS_ADDR] is rejected instead of aliasing.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int BITS_ADDR = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 ReqValid,
  output logic                 ReqReady,
  input  logic                 ReqWrite,
  input  logic [2:0]           Funct3,
  input  logic [31:0]          Addr,
  input  logic [31:0]          StoreData,
  output logic [31:0]          LoadData,
  output logic                 Done,
  output logic                 Error,
  output logic [BITS_ADDR-3:0] MemAddr,
  output logic [31:0]          MemWData,
  output logic                 MemWE,
  input  logic [31:0]          MemRData
);
  state_t               state_q, state_d;
  logic [BITS_ADDR-1:0] addr_q, addr_d;
  logic [2:0]           f3_q, f3_d;
  logic                 wr_q, wr_d;
  logic [31:0]          sd_q, sd_d, merge_q, merge_d, ld_q, ld_d;
  logic                 done_q, err_q;
  logic [31:0]          ld_val, st_val;
  logic                 oob;
`ifdef MEM_BOUNDS_CHECK_EN
  assign oob = |Addr[31:BITS_ADDR];
`else
  logic unused_hi;
  assign unused_hi = ^Addr[31:BITS_ADDR];
  assign oob = 1'b0;
`endif
  subword_align u_align (
    .word_i (MemRData),
    .off_i  (addr_q[1:0]),
    .f3_i   (f3_q),
    .sdata_i(sd_q),
    .load_o (ld_val),
    .store_o(st_val)
  );
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    wr_d    = wr_q;
    sd_d    = sd_q;
    merge_d = merge_q;
    ld_d    = ld_q;
    case (state_q)
      IDLE: if (ReqValid) begin
        addr_d  = Addr[BITS_ADDR-1:0];
        f3_d    = Funct3;
        wr_d    = ReqWrite;
        sd_d    = StoreData;
        state_d = (f3_bad(Funct3, Addr[1:0], ReqWrite) || oob) ? ERR :
                  (ReqWrite && Funct3 == F3_W) ? WR : RD;
      end
      RD: begin
        merge_d = wr_q ? st_val : merge_q;
        ld_d    = wr_q ? ld_q : ld_val;
        state_d = wr_q ? WR : DONE;
      end
      WR:      state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      wr_q    <= 1'b0;
      sd_q    <= '0;
      merge_q <= '0;
      ld_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      wr_q    <= wr_d;
      sd_q    <= sd_d;
      merge_q <= merge_d;
      ld_q    <= ld_d;
      done_q  <= state_d == DONE || state_d == ERR;
      err_q   <= state_d == ERR;
    end
  end
  // Write strobe decoded from state so an async reset drops it at once.
  assign MemWE    = state_q == WR;
  assign MemWData = (MemWE && f3_q == F3_W) ? sd_q : merge_q;
  assign MemAddr  = addr_q[BITS_ADDR-1:2];
  assign ReqReady = state_q == IDLE;
  assign LoadData = ld_q;
  assign Done     = done_q;
  assign Error    = err_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for mem_access_unit against a word-wide memory model
module tb_mem_access_unit;
  import mem_access_pkg::*;
  logic        CLK = 1'b0, RST = 1'b1, ReqValid = 1'b0, ReqWrite = 1'b0;
  logic [2:0]  Funct3 = 3'b000;
  logic [31:0] Addr = '0, StoreData = '0, MemRData;
  logic        ReqReady, Done, Error, MemWE;
  logic [31:0] LoadData, MemWData;
  logic [5:0]  MemAddr;
  logic [31:0] mem [64];
  typedef struct {
    logic        err;
    logic [31:0] ld;
    int          lat;
    int          we_cyc;
    logic [31:0] we_dat;
  } exp_t;
  exp_t        q[$];
  exp_t        e;
  int          checks = 0, errors = 0;
  logic        busy = 1'b0;
  int          cyc, we_n, we_cyc;
  logic [31:0] we_dat, last_ld = '0;

  always #5 CLK = ~CLK;
  assign MemRData = mem[MemAddr];
  always @(posedge CLK) if (MemWE) mem[MemAddr] <= MemWData;

  mem_access_unit #(.BITS_ADDR(8)) dut (
    .CLK(CLK), .RST(RST), .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
    .Funct3(Funct3), .Addr(Addr), .StoreData(StoreData), .LoadData(LoadData), .Done(Done),
    .Error(Error), .MemAddr(MemAddr), .MemWData(MemWData), .MemWE(MemWE), .MemRData(MemRData)
  );

  always @(negedge CLK) begin
    if (!busy) begin
      checks++;
      if (MemWE || Done) begin
        errors++;
        $display("FAIL idle_guard: MemWE=%b Done=%b, required 0 0", MemWE, Done);
      end
    end else begin
      cyc++;
      checks++;
      if (ReqReady) begin
        errors++;
        $display("FAIL busy_ready: ReqReady=1 in cycle T+%0d, required 0", cyc);
      end
      if (MemWE) begin
        we_n++;
        we_cyc = cyc;
        we_dat = MemWData;
      end
      if (Done) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard: Done with empty queue, required queued entry");
        end else begin
          e = q.pop_front();
          checks++;
          if (Error !== e.err) begin errors++; $display("FAIL error_flag: got %b, required %b", Error, e.err); end
          checks++;
          if (LoadData !== e.ld) begin errors++; $display("FAIL load_data: got %h, required %h", LoadData, e.ld); end
          checks++;
          if (cyc != e.lat) begin errors++; $display("FAIL latency: Done at T+%0d, required T+%0d", cyc, e.lat); end
          checks++;
          if (we_n != (e.we_cyc != 0 ? 1 : 0) || we_cyc != e.we_cyc) begin
            errors++;
            $display("FAIL write_pulse: %0d pulses last at T+%0d, required write at T+%0d", we_n, we_cyc, e.we_cyc);
          end
          if (e.we_cyc != 0) begin
            checks++;
            if (we_dat !== e.we_dat) begin errors++; $display("FAIL write_data: got %h, required %h", we_dat, e.we_dat); end
          end
        end
        busy = 1'b0;
      end
    end
  end

  task automatic send(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd, input exp_t x);
    q.push_back(x);
    @(negedge CLK);
    ReqValid = 1'b1; ReqWrite = w; Funct3 = f3; Addr = a; StoreData = sd;
    @(posedge CLK);
    #1 ReqValid = 1'b0;
    cyc = 0; we_n = 0; we_cyc = 0; we_dat = '0; busy = 1'b1;
    for (int i = 0; i < 10 && busy; i++) @(posedge CLK);
    if (busy) begin
      checks++; errors++;
      $display("FAIL timeout: no Done within 10 cycles of accept, required Done");
      busy = 1'b0;
      q.delete();
    end
  endtask

  task automatic load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] v);
    last_ld = v;
    send(1'b0, f3, a, 32'h0, '{1'b0, v, 2, 0, 32'h0});
  endtask

  task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd, input logic [31:0] wd);
    send(1'b1, f3, a, sd, '{1'b0, last_ld, f3 == F3_W ? 2 : 3, f3 == F3_W ? 1 : 2, wd});
  endtask

  task automatic bad(input logic w, input logic [2:0] f3, input logic [31:0] a);
    send(w, f3, a, 32'hFFFF_FFFF, '{1'b1, last_ld, 1, 0, 32'h0});
  endtask

  task automatic test_reset;
    repeat (2) @(negedge CLK);
    checks++; if (ReqReady !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b, required 1", ReqReady); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b, required 0", Done); end
    checks++; if (Error !== 1'b0) begin errors++; $display("FAIL rst_error: got %b, required 0", Error); end
    checks++; if (LoadData !== 32'h0) begin errors++; $display("FAIL rst_load: got %h, required 0", LoadData); end
    checks++; if (MemWData !== 32'h0) begin errors++; $display("FAIL rst_merge: got %h, required 0", MemWData); end
    RST = 1'b0;
  endtask

  task automatic test_loads;
    load(F3_B,  32'h13, 32'hFFFF_FF88);
    load(F3_HU, 32'h12, 32'h0000_8899);
    load(F3_BU, 32'h10, 32'h0000_00BB);
    load(F3_W,  32'h10, 32'h8899_AABB);
    load(F3_H,  32'h12, 32'hFFFF_8899);
    load(F3_B,  32'h11, 32'hFFFF_FFAA);
    load(F3_H,  32'h10, 32'hFFFF_AABB);
  endtask

  task automatic test_stores;
    store(F3_H, 32'h12, 32'hDEAD_1234, 32'h1234_AABB);
    load(F3_W, 32'h10, 32'h1234_AABB);
    store(F3_B, 32'h11, 32'hFFFF_FF55, 32'h1234_55BB);
    load(F3_B, 32'h11, 32'h0000_0055);
    store(F3_B, 32'h13, 32'h0000_0080, 32'h8034_55BB);
    load(F3_H, 32'h12, 32'hFFFF_8034);
    store(F3_W, 32'h14, 32'hCAFE_F00D, 32'hCAFE_F00D);
    load(F3_HU, 32'h16, 32'h0000_CAFE);
    store(F3_H, 32'h14, 32'h0000_BEEF, 32'hCAFE_BEEF);
    load(F3_W, 32'h14, 32'hCAFE_BEEF);
    store(F3_W, 32'h10, 32'h8899_AABB, 32'h8899_AABB);
    checks++; if (mem[4] !== 32'h8899_AABB) begin errors++; $display("FAIL mem_restore: got %h, required 8899aabb", mem[4]); end
  endtask

  task automatic test_errors;
    bad(1'b0, F3_W,   32'h11);
    bad(1'b1, F3_H,   32'h13);
    bad(1'b1, F3_BU,  32'h10);
    bad(1'b0, 3'b011, 32'h10);
    bad(1'b0, 3'b110, 32'h10);
    bad(1'b0, F3_HU,  32'h11);
    bad(1'b1, F3_W,   32'h12);
  endtask

  task automatic test_back_to_back;
    load(F3_B, 32'h12, 32'hFFFF_FF99);
    bad(1'b0, F3_H, 32'h11);
    load(F3_BU, 32'h12, 32'h0000_0099);
    store(F3_W, 32'h20, 32'h0102_0304, 32'h0102_0304);
    load(F3_B, 32'h23, 32'h0000_0001);
  endtask

  task automatic test_reset_abort;
    @(negedge CLK);
    ReqValid = 1'b1; ReqWrite = 1'b1; Funct3 = F3_B; Addr = 32'h10; StoreData = 32'h77;
    @(posedge CLK);
    #1 ReqValid = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    #1;
    checks++; if (ReqReady !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b, required 1", ReqReady); end
    checks++; if (MemWE !== 1'b0) begin errors++; $display("FAIL abort_we: got %b, required 0", MemWE); end
    checks++; if (LoadData !== 32'h0) begin errors++; $display("FAIL abort_load: got %h, required 0", LoadData); end
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    last_ld = '0;
    checks++; if (mem[4] !== 32'h8899_AABB) begin errors++; $display("FAIL abort_mem: got %h, required 8899aabb", mem[4]); end
    load(F3_W, 32'h10, 32'h8899_AABB);
  endtask

  task automatic test_bounds;
`ifdef MEM_BOUNDS_CHECK_EN
    bad(1'b0, F3_W, 32'h100);
    bad(1'b1, F3_W, 32'h8000_0010);
`else
    load(F3_W, 32'h110, 32'h8899_AABB);
    load(F3_B, 32'hFFFF_FF13, 32'hFFFF_FF88);
`endif
  endtask

  initial begin
    foreach (mem[i]) mem[i] = '0;
    mem[4] = 32'h8899_AABB;
    test_reset;
    test_loads;
    test_stores;
    test_errors;
    test_back_to_back;
    test_reset_abort;
    test_bounds;
    repeat (2) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
